// File: rtl/coefficient_load_controller_pkg.sv
// Shared definitions for the coefficient source, the load controller and the FIR.
// State encodings and default filter geometry live here so all three agree.
package coefficient_load_controller_pkg;

    localparam int DEFAULT_LENGTH     = 20;
    localparam int DEFAULT_DATA_WIDTH = 8;
    // Capture count must be able to hold LENGTH itself, so 2**COUNT_WIDTH > LENGTH.
    localparam int DEFAULT_COUNT_WIDTH = 5;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_ERROR = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        LOAD  = ST_LOAD,
        RUN   = ST_RUN,
        ERROR = ST_ERROR
    } state_t;

    function automatic int count_width_for(input int length);
        return $clog2(length + 1);
    endfunction

endpackage

// File: rtl/coefficient_load_controller_bank.sv
// Coefficient register bank: LENGTH x DATA_WIDTH, synchronous clear and single write port.
// Latency: write visible one edge after it is sampled; no backpressure, always accepts.
module coefficientBank #(
    parameter int LENGTH      = 20,
    parameter int DATA_WIDTH  = 8,
    parameter int INDEX_WIDTH = 5
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         writeEnable,
    input  logic [INDEX_WIDTH-1:0]       writeIndex,
    input  logic [DATA_WIDTH-1:0]        writeData,
    output logic [LENGTH*DATA_WIDTH-1:0] coefficients
);

    logic [DATA_WIDTH-1:0] regs [LENGTH];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < LENGTH; k++) regs[k] <= '0;
        end else begin
            for (int k = 0; k < LENGTH; k++) begin
                if (clear)
                    regs[k] <= '0;
                else if (writeEnable && writeIndex == INDEX_WIDTH'(k))
                    regs[k] <= writeData;
            end
        end
    end

    for (genvar g = 0; g < LENGTH; g++) begin : g_flat
        assign coefficients[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
    end

endmodule

// File: rtl/coefficient_load_controller.sv
// Sequences a coefficient load from the serial source into the bank, then enables the FIR.
// Latency: request -> busy after 2 edges; completion flag -> filterEnable/loadError after 1 edge.
// No backpressure: one coefficient accepted per cycle while busy; requests during a load are dropped.
module coefficient_load_controller
    import coefficient_load_controller_pkg::*;
#(
    parameter int LENGTH      = DEFAULT_LENGTH,
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int COUNT_WIDTH = DEFAULT_COUNT_WIDTH,
    parameter int TIMEOUT     = 64
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         loadRequest,
    input  logic signed [DATA_WIDTH-1:0] coefficientIn,
    input  logic                         coefficientValid,
    input  logic                         filterSetFlag,
    output logic                         coefficientEnable,
    output logic [LENGTH*DATA_WIDTH-1:0] coefficientsOut,
    output logic                         filterEnable,
    output logic                         busy,
    output logic                         loadError
);

    localparam int IDLE_WIDTH = $clog2(TIMEOUT + 1);

    state_t                  state;
    state_t                  nextState;
    logic                    requestPending;
    logic [COUNT_WIDTH-1:0]  count;
    logic [IDLE_WIDTH-1:0]   idleCount;

    logic                    startLoad;
    logic                    capture;
    logic                    overflow;
    logic                    timedOut;
    logic [COUNT_WIDTH-1:0]  countNext;
    logic [IDLE_WIDTH-1:0]   idleNext;

    assign startLoad = requestPending && (state != LOAD);
    assign capture   = (state == LOAD) && coefficientValid && (count < COUNT_WIDTH'(LENGTH));
    assign overflow  = (state == LOAD) && coefficientValid && (count == COUNT_WIDTH'(LENGTH));
    assign countNext = count + COUNT_WIDTH'(capture);
    assign idleNext  = coefficientValid ? '0 : idleCount + IDLE_WIDTH'(1);
    assign timedOut  = (state == LOAD) && !coefficientValid && (idleNext == IDLE_WIDTH'(TIMEOUT));

    // Completion counts the same-cycle capture; overflow and timeout win over the flag.
    always_comb begin
        nextState = state;
        case (state)
            IDLE, RUN, ERROR: if (requestPending) nextState = LOAD;
            LOAD: begin
                if (overflow || timedOut)
                    nextState = ERROR;
                else if (filterSetFlag)
                    nextState = (countNext == COUNT_WIDTH'(LENGTH)) ? RUN : ERROR;
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state             <= IDLE;
            requestPending    <= 1'b0;
            count             <= '0;
            idleCount         <= '0;
            coefficientEnable <= 1'b0;
            busy              <= 1'b0;
            filterEnable      <= 1'b0;
            loadError         <= 1'b0;
        end else begin
            state          <= nextState;
            requestPending <= loadRequest && (nextState != LOAD);
            if (startLoad) begin
                count     <= '0;
                idleCount <= '0;
            end else if (state == LOAD) begin
                count     <= countNext;
                idleCount <= idleNext;
            end
            coefficientEnable <= (nextState == LOAD);
            busy              <= (nextState == LOAD);
            filterEnable      <= (nextState == RUN);
            loadError         <= (nextState == ERROR);
        end
    end

    coefficientBank #(
        .LENGTH      (LENGTH),
        .DATA_WIDTH  (DATA_WIDTH),
        .INDEX_WIDTH (COUNT_WIDTH)
    ) u_bank (
        .clock        (clock),
        .reset        (reset),
        .clear        (startLoad),
        .writeEnable  (capture),
        .writeIndex   (count),
        .writeData    (coefficientIn),
        .coefficients (coefficientsOut)
    );

endmodule

// File: tb/tb_coefficient_load_controller.sv
module tb_coefficient_load_controller;

    localparam int LENGTH  = 20;
    localparam int DW      = 8;
    localparam int TIMEOUT = 64;
    localparam int W       = LENGTH * DW;

    logic                 clock = 1'b0;
    logic                 reset = 1'b0;
    logic                 loadRequest = 1'b0;
    logic signed [DW-1:0] coefficientIn = '0;
    logic                 coefficientValid = 1'b0;
    logic                 filterSetFlag = 1'b0;
    logic                 coefficientEnable;
    logic [W-1:0]         coefficientsOut;
    logic                 filterEnable;
    logic                 busy;
    logic                 loadError;

    int tests = 0;
    int fails = 0;

    int nominal[LENGTH] = '{34, 34, 0, 49, 125, -77, -51, 8, 98, 109,
                            -91, -3, 9, 1, 59, 75, 19, 58, -97, 10};

    typedef struct {
        logic          req;
        logic          vld;
        logic [DW-1:0] dat;
        logic          flag;
        logic          e_busy;
        logic          e_fen;
        logic          e_err;
    } vec_t;

    vec_t tbl[LENGTH + 3];

    coefficient_load_controller #(
        .LENGTH(LENGTH), .DATA_WIDTH(DW), .COUNT_WIDTH(5), .TIMEOUT(TIMEOUT)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .loadRequest       (loadRequest),
        .coefficientIn     (coefficientIn),
        .coefficientValid  (coefficientValid),
        .filterSetFlag     (filterSetFlag),
        .coefficientEnable (coefficientEnable),
        .coefficientsOut   (coefficientsOut),
        .filterEnable      (filterEnable),
        .busy              (busy),
        .loadError         (loadError)
    );

    always #5 clock = ~clock;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic req, input logic v, input logic [DW-1:0] d, input logic f);
        loadRequest      = req;
        coefficientValid = v;
        coefficientIn    = d;
        filterSetFlag    = f;
        @(posedge clock);
        #1;
        loadRequest      = 1'b0;
        coefficientValid = 1'b0;
        filterSetFlag    = 1'b0;
    endtask

    function automatic logic [W-1:0] pack(input int q[$]);
        logic [W-1:0] r = '0;
        for (int k = 0; k < q.size() && k < LENGTH; k++) r[k*DW +: DW] = DW'(q[k]);
        return r;
    endfunction

    function automatic vec_t mkvec(input logic req, input logic vld, input int dat, input logic flag,
                                   input logic eb, input logic ef, input logic ee);
        vec_t v;
        v.req = req; v.vld = vld; v.dat = DW'(dat); v.flag = flag;
        v.e_busy = eb; v.e_fen = ef; v.e_err = ee;
        return v;
    endfunction

    task automatic chk_state(input string name, input logic eb, input logic ef, input logic ee);
        chk({name, " busy"}, W'(busy), W'(eb));
        chk({name, " fen"},  W'(filterEnable), W'(ef));
        chk({name, " err"},  W'(loadError), W'(ee));
    endtask

    // Request, wait for LOAD, then stream values; flag optional on the last value.
    task automatic load_stream(input int vals[$], input logic flag_last);
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < vals.size(); i++)
            step(1'b0, 1'b1, DW'(vals[i]), flag_last && (i == vals.size() - 1));
    endtask

    initial begin
        int q[$];
        int neg[$];
        int cap[$];
        logic fen_seen;

        // Reset state
        #2;
        chk("reset busy", W'(busy), '0);
        chk("reset cen", W'(coefficientEnable), '0);
        chk("reset fen", W'(filterEnable), '0);
        chk("reset err", W'(loadError), '0);
        chk("reset bank", coefficientsOut, '0);
        @(negedge clock);
        reset = 1'b1;
        step(1'b0, 1'b0, '0, 1'b0);

        // Nominal load from the table
        tbl[0] = mkvec(1, 0, 0, 0, 0, 0, 0);
        tbl[1] = mkvec(0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < LENGTH; i++)
            tbl[2+i] = mkvec(0, 1, nominal[i], i == LENGTH-1, i != LENGTH-1, i == LENGTH-1, 0);
        tbl[LENGTH+2] = mkvec(0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < LENGTH + 3; i++) begin
            step(tbl[i].req, tbl[i].vld, tbl[i].dat, tbl[i].flag);
            chk($sformatf("vec%0d busy", i), W'(busy), W'(tbl[i].e_busy));
            chk($sformatf("vec%0d cen", i), W'(coefficientEnable), W'(tbl[i].e_busy));
            chk($sformatf("vec%0d fen", i), W'(filterEnable), W'(tbl[i].e_fen));
            chk($sformatf("vec%0d err", i), W'(loadError), W'(tbl[i].e_err));
            if (tbl[i].vld)
                chk($sformatf("vec%0d lane", i), W'(coefficientsOut[(i-2)*DW +: DW]), W'(tbl[i].dat));
        end
        q = {};
        foreach (nominal[i]) q.push_back(nominal[i]);
        chk("nominal bank", coefficientsOut, pack(q));

        // Reload with negated set: filterEnable drops as busy rises
        step(1'b1, 1'b0, '0, 1'b0);
        chk_state("reload req", 0, 1, 0);
        step(1'b0, 1'b0, '0, 1'b0);
        chk_state("reload enter", 1, 0, 0);
        chk("reload cleared", coefficientsOut, '0);
        neg = {};
        foreach (nominal[i]) neg.push_back(-nominal[i]);
        fen_seen = 1'b0;
        for (int i = 0; i < LENGTH; i++) begin
            step(1'b0, 1'b1, DW'(neg[i]), i == LENGTH-1);
            if (i != LENGTH-1 && filterEnable) fen_seen = 1'b1;
        end
        chk("reload fen low", W'(fen_seen), '0);
        chk_state("reload done", 0, 1, 0);
        chk("reload bank", coefficientsOut, pack(neg));

        // Underrun: flag on the 19th value
        q = {};
        for (int i = 0; i < LENGTH-1; i++) q.push_back(int'($urandom_range(0, 255)));
        load_stream(q, 1'b1);
        chk_state("underrun", 0, 0, 1);
        chk("underrun lane19", W'(coefficientsOut[19*DW +: DW]), '0);
        chk("underrun bank", coefficientsOut, pack(q));

        // Overflow then recovery
        q = {};
        for (int i = 0; i < LENGTH+1; i++) q.push_back(int'($urandom_range(0, 255)));
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < LENGTH; i++) step(1'b0, 1'b1, DW'(q[i]), 1'b0);
        chk_state("overflow full", 1, 0, 0);
        step(1'b0, 1'b1, DW'(q[LENGTH]), 1'b0);
        chk_state("overflow", 0, 0, 1);
        void'(q.pop_back());
        chk("overflow bank", coefficientsOut, pack(q));
        load_stream(neg, 1'b1);
        chk_state("recovery", 0, 1, 0);
        chk("recovery bank", coefficientsOut, pack(neg));

        // Timeout boundary: 63 silent cycles still loading, the 64th errors
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < TIMEOUT-1; i++) step(1'b0, 1'b0, '0, 1'b0);
        chk_state("timeout-1", 1, 0, 0);
        step(1'b0, 1'b0, '0, 1'b0);
        chk_state("timeout", 0, 0, 1);
        chk("timeout cen", W'(coefficientEnable), '0);

        // Request during LOAD is ignored and the count carries on
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, DW'(nominal[i]), 1'b0);
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        for (int i = 10; i < LENGTH; i++) step(1'b0, 1'b1, DW'(nominal[i]), i == LENGTH-1);
        chk_state("ignored req", 0, 1, 0);
        q = {};
        foreach (nominal[i]) q.push_back(nominal[i]);
        chk("ignored req bank", coefficientsOut, pack(q));
        step(1'b0, 1'b0, '0, 1'b0);
        chk_state("no spurious reload", 0, 1, 0);

        // Asynchronous reset mid-load
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, DW'(neg[i]), 1'b0);
        #2 reset = 1'b0;
        #1;
        chk_state("midreset", 0, 0, 0);
        chk("midreset cen", W'(coefficientEnable), '0);
        chk("midreset bank", coefficientsOut, '0);
        #2 reset = 1'b1;
        step(1'b0, 1'b0, '0, 1'b0);
        chk_state("after reset", 0, 0, 0);

        // Randomized scenarios against a stream-level outcome model
        for (int s = 0; s < 30; s++) begin
            int kind, n, gap;
            logic cv[$];
            int   cd[$];
            logic cf[$];
            int   outcome, stop_at, silence;
            logic busy_ok;
            cv = {}; cd = {}; cf = {};
            kind = int'($urandom_range(0, 3));
            n = (kind == 0) ? LENGTH : (kind == 2) ? int'($urandom_range(LENGTH+1, LENGTH+3))
                                                    : int'($urandom_range(0, LENGTH-1));
            for (int i = 0; i < n; i++) begin
                gap = ($urandom_range(0, 9) == 0) ? int'($urandom_range(60, 66)) : int'($urandom_range(0, 3));
                for (int g = 0; g < gap; g++) begin cv.push_back(0); cd.push_back(0); cf.push_back(0); end
                cv.push_back(1); cd.push_back(int'($urandom_range(0, 255)));
                cf.push_back(kind == 0 && i == n-1);
            end
            if (kind == 1) begin cv.push_back(0); cd.push_back(0); cf.push_back(1); end
            if (kind == 3)
                for (int g = 0; g < TIMEOUT; g++) begin cv.push_back(0); cd.push_back(0); cf.push_back(0); end

            // Model: 0 = still loading, 1 = run, 2 = error
            cap = {}; outcome = 0; stop_at = cv.size() - 1; silence = 0;
            for (int i = 0; i < cv.size() && outcome == 0; i++) begin
                if (cv[i]) begin
                    silence = 0;
                    if (cap.size() == LENGTH) outcome = 2;
                    else cap.push_back(cd[i]);
                end else begin
                    silence++;
                    if (silence == TIMEOUT) outcome = 2;
                end
                if (outcome == 0 && cf[i]) outcome = (cap.size() == LENGTH) ? 1 : 2;
                if (outcome != 0) stop_at = i;
            end

            step(1'b1, 1'b0, '0, 1'b0);
            step(1'b0, 1'b0, '0, 1'b0);
            busy_ok = 1'b1;
            for (int i = 0; i <= stop_at; i++) begin
                if (!busy) busy_ok = 1'b0;
                step(1'b0, cv[i], DW'(cd[i]), cf[i]);
            end
            chk($sformatf("rand%0d busy during", s), W'(busy_ok), W'(1));
            chk_state($sformatf("rand%0d k%0d end", s, kind), outcome == 0, outcome == 1, outcome == 2);
            chk($sformatf("rand%0d bank", s), coefficientsOut, pack(cap));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/coefficient_load_controller.md
# coefficient_load_controller

Sequencer between the `setupCoefficients` coefficient source and the matched-filter FIR datapath. On request it enables the coefficient source and captures the serial coefficient stream into a parallel register bank. It checks the stream against the source's completion flag, then enables the filter's sample path. Covers power-up load, run-time reload, and error/timeout recovery.

## Interface

Parameters:

- `LENGTH`, 20: number of filter coefficients.
- `DATA_WIDTH`, 8: signed coefficient width.
- `COUNT_WIDTH`, 5: capture counter width; must satisfy 2^COUNT_WIDTH > LENGTH.
- `TIMEOUT`, 64: maximum consecutive LOAD cycles without `coefficientValid` before error.

Ports:

- `clock`, in, 1: single clock for the block.
- `reset`, in, 1: asynchronous, active-low reset.
- `loadRequest`, in, 1: single-cycle request to (re)load coefficients.
- `coefficientIn`, in, DATA_WIDTH signed: serial coefficient from the source (`coefficientOut`).
- `coefficientValid`, in, 1: `coefficientIn` is valid this cycle.
- `filterSetFlag`, in, 1: source reports all coefficients sent.
- `coefficientEnable`, out, 1: drives the source's `enable`.
- `coefficientsOut`, out, LENGTH*DATA_WIDTH: coefficient bank; coefficient k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- `filterEnable`, out, 1: gates the FIR sample path; high only when the bank is complete.
- `busy`, out, 1: high while in LOAD.
- `loadError`, out, 1: high while in ERROR.

## Operation

The FSM has four states: IDLE, LOAD, RUN, ERROR. Transitions:

- **IDLE**: `loadRequest` moves to LOAD.
- **RUN**: `loadRequest` moves to LOAD. This is a reload.
- **ERROR**: `loadRequest` moves to LOAD. Only `loadRequest` or `reset` leaves ERROR.
- **Entry to LOAD**: clears the bank to 0, `count` to 0 and `idleCount` to 0.
- **LOAD capture**: each cycle with `coefficientValid` high and `count` < LENGTH writes `coefficientIn` to bank[count], then increments `count`.
- **LOAD completion**: when `filterSetFlag` is sampled high, count the capture made in the same cycle first. Then go to RUN if the total equals LENGTH, otherwise go to ERROR (underrun).
- **LOAD overflow**: `coefficientValid` with `count` == LENGTH goes to ERROR.
- **LOAD timeout**: `idleCount` increments on cycles without `coefficientValid` and resets to 0 on a valid cycle. Reaching TIMEOUT goes to ERROR.
- **LOAD and requests**: `loadRequest` during LOAD is ignored.

Outputs by state:

- `coefficientEnable` = `busy` = (state == LOAD).
- `filterEnable` = (state == RUN).
- `loadError` = (state == ERROR).
- All outputs are registered, decoded from the registered state.

Data handling:

- Coefficients are stored unmodified; no sign extension or scaling.
- The bank holds its contents in RUN and ERROR.

## Timing

- **Reset values**: state IDLE; bank, `count` and `idleCount` all 0; every output 0.
- **Reset mid-operation**: `reset` low at any point, including mid-LOAD, applies the reset values immediately; it is asynchronous.
- **Request latency**: `loadRequest` sampled at edge N → `coefficientEnable` and `busy` high after edge N+1.
- **Reload**: `filterEnable` drops on the same edge that `busy` rises; the filter never runs on a partial bank.
- **Capture**: a valid coefficient sampled at edge M is visible on `coefficientsOut` after edge M.
- **Completion**: `filterSetFlag` sampled at edge F → `filterEnable` high (or `loadError` high) after edge F. `coefficientEnable` drops on that same edge.
- **Error precedence**: if overflow, timeout and `filterSetFlag` coincide in one cycle, go to ERROR.
- **Throughput**: back-to-back valids are accepted every cycle. Minimum load is LENGTH+1 cycles from request to `filterEnable`.

## Structure

- A shared package holds:
  - state encodings (2-bit localparams IDLE/LOAD/RUN/ERROR);
  - default LENGTH and DATA_WIDTH, shared with `setupCoefficients` and the FIR;
  - a COUNT_WIDTH derivation note.
- One sub-module, `coefficientBank`. It is a LENGTH × DATA_WIDTH register array with these ports:
  - clear;
  - write enable;
  - write index;
  - write data;
  - flattened read-out.
- The FSM and counters stay in the top level.

## Test plan

- **Nominal load**: reset, then `loadRequest`; source streams 34, 34, 0, 49, 125, −77, −51, 8, 98, 109, −91, −3, 9, 1, 59, 75, 19, 58, −97, 10 with `filterSetFlag` on the last valid. Required: bank matches in order, `filterEnable` rises the cycle after, `coefficientEnable` falls on the same edge.
- **Underrun**: `filterSetFlag` arrives after 19 valids. Required: `loadError`=1, `filterEnable`=0, bank[19]=0.
- **Overflow and recovery**: a 21st valid before `filterSetFlag` → ERROR. A following `loadRequest` with a clean stream → RUN.
- **Timeout**: no valid for 64 cycles in LOAD → `loadError`=1, `busy`=0.
- **Reload**: in RUN, pulse `loadRequest`. Required: `filterEnable` low for the whole reload, bank cleared then refilled with a second set (all values negated).
- **Reset mid-load**: `reset` low after 10 valids → all outputs 0 immediately. `loadRequest` during LOAD is ignored; `count` does not restart.
